// File: rtl/ff_bank_rr_arbiter_if.sv
// Bus bundle between the requesters and the shared flip-flop register bank arbiter.
interface ff_bank_rr_arbiter_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NREQ  = 4,
  parameter int unsigned IDW   = 2
);
  logic [NREQ-1:0]       req;
  logic [2*NREQ-1:0]     op;
  logic [WIDTH*NREQ-1:0] wdata;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       ack;
  logic [IDW-1:0]        owner;
  logic                  busy;
  logic [WIDTH-1:0]      q;

  modport master (output req, op, wdata, input gnt, ack, owner, busy, q);
  modport slave  (input req, op, wdata, output gnt, ack, owner, busy, q);
endinterface

// File: rtl/ff_bank_rr_arbiter.sv
// Round-robin arbiter that grants one requester per 3-cycle transaction and applies
// its LOAD/SET/CLEAR/HOLD command to a shared WIDTH-bit register bank.
module ff_bank_rr_arbiter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NREQ  = 4,
  parameter int unsigned IDW   = 2
) (
  input logic                  clk,
  input logic                  rst_n,
  ff_bank_rr_arbiter_if.slave  bus_io
);
  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_SET   = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;

  typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_ACK} state_e;

  state_e           state_q;
  logic [IDW-1:0]   ptr_q;
  logic [IDW-1:0]   owner_q;
  logic [NREQ-1:0]  gnt_q;
  logic [NREQ-1:0]  ack_q;
  logic             busy_q;
  logic [WIDTH-1:0] q_q;

  logic [IDW-1:0]   win_c;
  logic             req_w_c;
  logic [1:0]       op_w_c;
  logic [WIDTH-1:0] wdata_w_c;

  // Nearest requester after ptr wins: scan farthest-first so the closest overwrites.
  always_comb begin : rr_pick
    win_c = ptr_q;
    for (int k = int'(NREQ); k >= 1; k--) begin
      if (bus_io.req[(int'(ptr_q) + k) % int'(NREQ)]) begin
        win_c = IDW'((int'(ptr_q) + k) % int'(NREQ));
      end
    end
  end

  always_comb begin : owner_mux
    req_w_c   = bus_io.req[owner_q];
    op_w_c    = bus_io.op[2*int'(owner_q) +: 2];
    wdata_w_c = bus_io.wdata[int'(WIDTH)*int'(owner_q) +: WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin : fsm
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= IDW'(NREQ - 1);
      owner_q <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
      q_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|bus_io.req) begin
            owner_q <= win_c;
            gnt_q   <= NREQ'(1) << win_c;
            busy_q  <= 1'b1;
            state_q <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (req_w_c) begin
            case (op_w_c)
              OP_LOAD:  q_q <= wdata_w_c;
              OP_SET:   q_q <= '1;
              OP_CLEAR: q_q <= '0;
              default:  q_q <= q_q;
            endcase
            ptr_q   <= owner_q;
            ack_q   <= gnt_q;
            state_q <= ST_ACK;
          end else begin
            // Owner withdrew before commit: drop the grant, leave ptr untouched.
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_ACK: begin
          gnt_q   <= '0;
          ack_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus_io.gnt   = gnt_q;
  assign bus_io.ack   = ack_q;
  assign bus_io.owner = owner_q;
  assign bus_io.busy  = busy_q;
  assign bus_io.q     = q_q;
endmodule

// File: tb/tb_ff_bank_rr_arbiter.sv
// Bench for ff_bank_rr_arbiter: directed vector table, async-reset sequence,
// then random traffic against a transaction-level reference model.
module tb_ff_bank_rr_arbiter;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned NREQ  = 4;
  localparam int unsigned IDW   = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ff_bank_rr_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) bus ();

  ff_bank_rr_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  typedef struct {
    logic [3:0]  req;
    logic [7:0]  op;
    logic [31:0] wdata;
    logic [3:0]  g;
    logic [3:0]  a;
    logic        b;
    logic [1:0]  o;
    logic [7:0]  q;
  } vec_t;

  vec_t vecs[$];
  int   n_chk = 0;
  int   n_err = 0;

  // Reference model: phase 0 idle, 1 granted, 2 acknowledged
  int         m_phase, m_w, m_ptr;
  logic [7:0] m_q;

  function automatic void add(input logic [3:0] r, input logic [7:0] o, input logic [31:0] wd,
                              input logic [3:0] g, input logic [3:0] a, input logic b,
                              input logic [1:0] ow, input logic [7:0] qv);
    vec_t v;
    v.req = r; v.op = o; v.wdata = wd; v.g = g; v.a = a; v.b = b; v.o = ow; v.q = qv;
    vecs.push_back(v);
  endfunction

  function void model_reset();
    m_phase = 0; m_w = 0; m_ptr = int'(NREQ) - 1; m_q = 8'h00;
  endfunction

  function void model_step(input logic [3:0] r, input logic [7:0] o, input logic [31:0] wd);
    int opc;
    bit found;
    if (m_phase == 0) begin
      if (r != 4'b0) begin
        found = 1'b0;
        for (int k = 1; k <= int'(NREQ); k++) begin
          if (!found && r[(m_ptr + k) % int'(NREQ)]) begin
            m_w = (m_ptr + k) % int'(NREQ);
            found = 1'b1;
          end
        end
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (r[m_w]) begin
        opc = int'((o >> (2 * m_w)) & 8'h03);
        if (opc == 0)      m_q = 8'(wd >> (8 * m_w));
        else if (opc == 1) m_q = 8'hFF;
        else if (opc == 2) m_q = 8'h00;
        m_ptr = m_w;
        m_phase = 2;
      end else begin
        m_phase = 0;
      end
    end else begin
      m_phase = 0;
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] g, input logic [3:0] a,
                         input logic b, input logic [1:0] o, input logic [7:0] qv);
    chk({tag, ".gnt"},   32'(bus.gnt),   32'(g));
    chk({tag, ".ack"},   32'(bus.ack),   32'(a));
    chk({tag, ".busy"},  32'(bus.busy),  32'(b));
    chk({tag, ".owner"}, 32'(bus.owner), 32'(o));
    chk({tag, ".q"},     32'(bus.q),     32'(qv));
  endtask

  task automatic chk_model(input string tag);
    logic [3:0] eg;
    eg = 4'(1 << m_w);
    chk_out(tag, (m_phase != 0) ? eg : 4'h0, (m_phase == 2) ? eg : 4'h0,
            m_phase != 0, 2'(m_w), m_q);
  endtask

  task automatic step(input logic [3:0] r, input logic [7:0] o, input logic [31:0] wd);
    bus.req = r; bus.op = o; bus.wdata = wd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0]  ops   [4];
    logic [7:0]  qexp  [4];
    logic [7:0]  qprev;
    logic [3:0]  r;
    logic [7:0]  o;
    logic [31:0] wd;
    int          w;

    // Round-robin with everyone requesting, LOAD of 8'h10+i
    for (int g = 0; g < 5; g++) begin
      w = g % 4;
      qprev = (g == 0) ? 8'h00 : 8'(8'h10 + (g - 1) % 4);
      add(4'hF, 8'h00, 32'h13121110, 4'(1 << w), 4'h0,       1'b1, 2'(w), qprev);
      add(4'hF, 8'h00, 32'h13121110, 4'(1 << w), 4'(1 << w), 1'b1, 2'(w), 8'(8'h10 + w));
      add(4'hF, 8'h00, 32'h13121110, 4'h0,       4'h0,       1'b0, 2'(w), 8'(8'h10 + w));
    end
    // Single LOAD from requester 2
    add(4'b0100, 8'h00, 32'h00A50000, 4'b0100, 4'b0000, 1'b1, 2'd2, 8'h10);
    add(4'b0100, 8'h00, 32'h00A50000, 4'b0100, 4'b0100, 1'b1, 2'd2, 8'hA5);
    add(4'b0000, 8'h00, 32'h00A50000, 4'b0000, 4'b0000, 1'b0, 2'd2, 8'hA5);
    // Requester 1: SET, CLEAR, LOAD 3C, HOLD
    ops  = '{8'b0000_0100, 8'b0000_1000, 8'b0000_0000, 8'b0000_1100};
    qexp = '{8'hFF, 8'h00, 8'h3C, 8'h3C};
    qprev = 8'hA5;
    for (int i = 0; i < 4; i++) begin
      add(4'b0010, ops[i], 32'h00003C00, 4'b0010, 4'b0000, 1'b1, 2'd1, qprev);
      add(4'b0010, ops[i], 32'h00003C00, 4'b0010, 4'b0010, 1'b1, 2'd1, qexp[i]);
      add(4'b0000, ops[i], 32'h00003C00, 4'b0000, 4'b0000, 1'b0, 2'd1, qexp[i]);
      qprev = qexp[i];
    end
    // Cancel during GRANT, then 0011 goes to requester 0
    add(4'b0010, 8'h00, 32'h00000077, 4'b0010, 4'b0000, 1'b1, 2'd1, 8'h3C);
    add(4'b0000, 8'h00, 32'h00000077, 4'b0000, 4'b0000, 1'b0, 2'd1, 8'h3C);
    add(4'b0011, 8'h00, 32'h00000077, 4'b0001, 4'b0000, 1'b1, 2'd0, 8'h3C);
    add(4'b0011, 8'h00, 32'h00000077, 4'b0001, 4'b0001, 1'b1, 2'd0, 8'h77);
    add(4'b0000, 8'h00, 32'h00000077, 4'b0000, 4'b0000, 1'b0, 2'd0, 8'h77);

    rst_n = 1'b0; bus.req = '0; bus.op = '0; bus.wdata = '0;
    repeat (2) @(posedge clk);
    #1 chk_out("reset", 4'h0, 4'h0, 1'b0, 2'd0, 8'h00);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(4'h0, 8'h00, 32'h0);
      chk_out("idle", 4'h0, 4'h0, 1'b0, 2'd0, 8'h00);
    end

    foreach (vecs[i]) begin
      step(vecs[i].req, vecs[i].op, vecs[i].wdata);
      chk_out($sformatf("vec%0d", i), vecs[i].g, vecs[i].a, vecs[i].b, vecs[i].o, vecs[i].q);
    end

    // Async reset in the middle of a pending LOAD
    step(4'b1000, 8'h00, 32'h55000000); chk_out("pre.gnt",  4'b1000, 4'b0000, 1'b1, 2'd3, 8'h77);
    step(4'b1000, 8'h00, 32'h55000000); chk_out("pre.ack",  4'b1000, 4'b1000, 1'b1, 2'd3, 8'h55);
    step(4'b0000, 8'h00, 32'h55000000); chk_out("pre.idle", 4'b0000, 4'b0000, 1'b0, 2'd3, 8'h55);
    step(4'b1000, 8'h00, 32'hAA000000); chk_out("arst.gnt", 4'b1000, 4'b0000, 1'b1, 2'd3, 8'h55);
    #2 rst_n = 1'b0;
    #1 chk_out("arst.now", 4'h0, 4'h0, 1'b0, 2'd0, 8'h00);
    @(posedge clk);
    #1 chk_out("arst.hold", 4'h0, 4'h0, 1'b0, 2'd0, 8'h00);
    @(negedge clk) rst_n = 1'b1;
    step(4'b1000, 8'h00, 32'hAA000000); chk_out("post.gnt",  4'b1000, 4'b0000, 1'b1, 2'd3, 8'h00);
    step(4'b1000, 8'h00, 32'hAA000000); chk_out("post.ack",  4'b1000, 4'b1000, 1'b1, 2'd3, 8'hAA);
    step(4'b0000, 8'h00, 32'hAA000000); chk_out("post.idle", 4'b0000, 4'b0000, 1'b0, 2'd3, 8'hAA);

    // Random traffic with occasional mid-cycle resets
    rst_n = 1'b0;
    @(posedge clk);
    #1 model_reset();
    @(negedge clk) rst_n = 1'b1;
    for (int c = 0; c < 800; c++) begin
      r  = 4'($urandom) & 4'($urandom);
      o  = 8'($urandom);
      wd = $urandom;
      bus.req = r; bus.op = o; bus.wdata = wd;
      @(posedge clk);
      model_step(r, o, wd);
      #1 chk_model($sformatf("rnd%0d", c));
      if ($urandom_range(0, 99) == 0) begin
        #2 rst_n = 1'b0;
        #1 model_reset();
        chk_model($sformatf("rnd%0d.arst", c));
        @(negedge clk) rst_n = 1'b1;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/ff_bank_rr_arbiter.md
Name: ff_bank_rr_arbiter

Overview:
- Round-robin arbiter and sequencer for a shared WIDTH-bit register bank built from posedge flip-flops with synchronous set/clear/load control.
- Up to NREQ requesters ask for access. One is granted per transaction, and its command (load, set, clear or hold) is applied to the bank.
- The bank contents are exported as q. The block sits between bus-side requesters and the flip-flop register resource.

Parameters:
- WIDTH, 8, width of the shared register bank.
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of the owner index; must equal clog2(NREQ).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  NREQ  per-requester request level; bit i belongs to requester i.
- op  input  2*NREQ  per-requester command; bits [2i+1:2i] belong to requester i. 00 LOAD, 01 SET, 10 CLEAR, 11 HOLD.
- wdata  input  WIDTH*NREQ  per-requester load data; slice [WIDTH*(i+1)-1:WIDTH*i].
- gnt  output  NREQ  one-hot grant.
- ack  output  NREQ  one-hot, single-cycle completion pulse.
- owner  output  IDW  index of the current or last granted requester.
- busy  output  1  high while a transaction is in progress (GRANT or ACK).
- q  output  WIDTH  shared register bank contents.

Behaviour:
- Reset (rst_n=0, asynchronous, any state): state=IDLE, gnt=0, ack=0, busy=0, owner=0, q=0, rr pointer ptr=NREQ-1, so requester 0 wins first. Release is synchronous to clk.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- FSM states: IDLE, GRANT, ACK.
- IDLE:
  - If req!=0, select the first i with req[i]=1, searching ptr+1, ptr+2, ... with wrap modulo NREQ.
  - Register the winner w and owner<=w, then go to GRANT.
  - If req==0, stay in IDLE with gnt=0 and busy=0.
- GRANT (1 cycle): gnt[w]=1, busy=1. At the end of this cycle, sample req[w], op_w and wdata_w.
  - req[w]=1 with LOAD: q<=wdata_w.
  - req[w]=1 with SET: q<=all ones.
  - req[w]=1 with CLEAR: q<=0.
  - req[w]=1 with HOLD: q unchanged.
  - In all four cases: ptr<=w, go to ACK.
  - req[w]=0 (cancel): q unchanged, ptr unchanged, no ack, go to IDLE.
- ACK (1 cycle): gnt[w]=1, ack[w]=1, busy=1; q already shows the new value. Go to IDLE unconditionally.
- Latency:
  - req sampled in IDLE at edge n.
  - gnt visible in cycle n+1.
  - q updated and ack visible in cycle n+2.
  - gnt drops at cycle n+3.
  - Throughput is one transaction per 3 cycles.
- Requester rules:
  - Hold op and wdata stable while gnt is high.
  - Drop req in the cycle after ack if no further access is wanted; a still-high req is re-arbitrated normally.
- Fairness: after serving w, w has the lowest priority. With all requests held high, the grant order is 0,1,...,NREQ-1,0,...
- Single requester: served back-to-back, once every 3 cycles.
- Requests arriving while busy are ignored until IDLE; no queuing.
- op is meaningful only for the granted requester. Other requesters' op and wdata never affect q.
- Asynchronous reset mid-transaction aborts it: q=0 even if a LOAD was pending, and no ack is issued.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, then req=0 for 10 cycles -> q=8'h00, gnt=0, ack=0, busy=0, owner=0 throughout.
- Single LOAD: req=4'b0100, op2=00, wdata2=8'hA5 -> gnt=4'b0100 one cycle later; next cycle ack=4'b0100 and q=8'hA5; following cycle gnt=0, busy=0.
- Round-robin, all requesting:
  - Stimulus: req=4'b1111 held, op=LOAD, wdata_i=8'h10+i.
  - Required: grants in order 0,1,2,3,0 at 3-cycle spacing; q sequence 8'h10, 8'h11, 8'h12, 8'h13, 8'h10; owner tracks each grant.
- Command set:
  - Requester 1 runs SET -> q=8'hFF.
  - Then CLEAR -> q=8'h00.
  - Then LOAD 8'h3C -> q=8'h3C.
  - Then HOLD -> q stays 8'h3C and ack still pulses.
- Cancel: req=4'b0010 in IDLE, then req[1]=0 during GRANT -> q unchanged, no ack. FSM back to IDLE with ptr unchanged, and a later req=4'b0011 grants requester 0 first.
- Async reset mid-operation: q=8'h55, LOAD 8'hAA started, rst_n pulled low during GRANT (between edges) -> gnt, busy and q clear to 0 immediately, no ack. After release, req=4'b1000 is granted normally.
